pc_sequencer: RTL and testbench

//  Program-counter sequencer for FRANK6000; sits directly upstream of the instruction stack.

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for FRANK6000: selects the next PC and drives the instruction
// stack's push/pop strobes, mirroring its depth to flag overflow and underflow.
module pc_sequencer #(
  parameter int data_width = 8,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_jmp,
  input  logic                  i_brz,
  input  logic                  i_zero,
  input  logic                  i_call,
  input  logic                  i_rtrn,
  input  logic [data_width-1:0] i_target,
  input  logic [data_width-1:0] i_stack,
  output logic [data_width-1:0] o_PC,
  output logic                  o_call,
  output logic                  o_rtrn,
  output logic                  o_busy,
  output logic                  o_ovf,
  output logic                  o_unf
);

  typedef enum logic {RUN, RET_WAIT} state_t;

  localparam logic [addr_width:0] DEPTH_MAX = {1'b1, {addr_width{1'b0}}};

  state_t                state;
  state_t                state_next;
  logic [data_width-1:0] pc_next;
  logic [data_width-1:0] pc_inc;
  logic [addr_width:0]   depth;
  logic [addr_width:0]   depth_next;
  logic                  ovf_next;
  logic                  unf_next;

  assign pc_inc = o_PC + data_width'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      o_PC  <= '0;
      depth <= '0;
      o_ovf <= 1'b0;
      o_unf <= 1'b0;
    end else begin
      state <= state_next;
      o_PC  <= pc_next;
      depth <= depth_next;
      o_ovf <= ovf_next;
      o_unf <= unf_next;
    end
  end

  // The stack's read is registered, so a pop spends one cycle in RET_WAIT before i_stack is valid.
  always_comb begin
    state_next = state;
    pc_next    = o_PC;
    depth_next = depth;
    ovf_next   = o_ovf;
    unf_next   = o_unf;
    o_call     = 1'b0;
    o_rtrn     = 1'b0;
    o_busy     = 1'b0;
    case (state)
      RUN: begin
        if (i_en) begin
          if (i_rtrn) begin
            if (depth != '0) begin
              o_rtrn     = 1'b1;
              depth_next = depth - (addr_width + 1)'(1);
              state_next = RET_WAIT;
            end else begin
              unf_next = 1'b1;
              pc_next  = pc_inc;
            end
          end else if (i_call) begin
            if (depth != DEPTH_MAX) begin
              o_call     = 1'b1;
              depth_next = depth + (addr_width + 1)'(1);
              pc_next    = i_target;
            end else begin
              ovf_next = 1'b1;
              pc_next  = pc_inc;
            end
          end else if (i_jmp) begin
            pc_next = i_target;
          end else if (i_brz) begin
            pc_next = i_zero ? i_target : pc_inc;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
      RET_WAIT: begin
        o_busy     = 1'b1;
        pc_next    = i_stack;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: emulates the instruction stack around the DUT, checks every cycle
// against a queue-based model, and pins the model with hand-computed PC/strobe values.
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       i_en, i_jmp, i_brz, i_zero, i_call, i_rtrn;
  logic [7:0] i_target, i_stack;
  logic [7:0] o_PC;
  logic       o_call, o_rtrn, o_busy, o_ovf, o_unf;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;

  // Stack environment (registered read) and values sampled during the last applied cycle
  logic [7:0] env_mem [16];
  int         env_sp = 0;
  logic       last_call, last_rtrn, last_busy;
  logic [7:0] last_pc;

  // Reference model: return addresses kept in a plain queue
  logic [7:0] m_ret [$];
  logic [7:0] m_pc, m_pending;
  logic       m_busy, m_ovf, m_unf;

  pc_sequencer #(.data_width(8), .addr_width(4)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_jmp(i_jmp), .i_brz(i_brz), .i_zero(i_zero),
    .i_call(i_call), .i_rtrn(i_rtrn), .i_target(i_target), .i_stack(i_stack),
    .o_PC(o_PC), .o_call(o_call), .o_rtrn(o_rtrn), .o_busy(o_busy), .o_ovf(o_ovf), .o_unf(o_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 8'h00; m_busy = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_pending = 8'h00;
      m_ret.delete();
    end else if (m_busy) begin
      m_pc = m_pending;
      m_busy = 1'b0;
    end else if (i_en) begin
      if (i_rtrn) begin
        if (m_ret.size() > 0) begin m_pending = m_ret.pop_back(); m_busy = 1'b1; end
        else begin m_unf = 1'b1; m_pc = m_pc + 8'd1; end
      end else if (i_call) begin
        if (m_ret.size() < 16) begin m_ret.push_back(m_pc + 8'd1); m_pc = i_target; end
        else begin m_ovf = 1'b1; m_pc = m_pc + 8'd1; end
      end else if (i_jmp) m_pc = i_target;
      else if (i_brz) m_pc = i_zero ? i_target : m_pc + 8'd1;
      else m_pc = m_pc + 8'd1;
    end
  end

  always @(negedge clk) begin
    logic exp_call, exp_rtrn;
    if (chk_on) begin
      exp_call = !m_busy && i_en && !i_rtrn && i_call && (m_ret.size() < 16);
      exp_rtrn = !m_busy && i_en && i_rtrn && (m_ret.size() > 0);
      check_output("model_pc",   o_PC,          m_pc);
      check_output("model_call", {7'd0, o_call}, {7'd0, exp_call});
      check_output("model_rtrn", {7'd0, o_rtrn}, {7'd0, exp_rtrn});
      check_output("model_busy", {7'd0, o_busy}, {7'd0, m_busy});
      check_output("model_ovf",  {7'd0, o_ovf},  {7'd0, m_ovf});
      check_output("model_unf",  {7'd0, o_unf},  {7'd0, m_unf});
    end
  end

  // One clock cycle of commands; the stack emulator reacts to the DUT's own strobes
  task automatic apply_stimulus(input logic en, rtrn, call, jmp, brz, zero, input logic [7:0] tgt);
    i_en = en; i_rtrn = rtrn; i_call = call; i_jmp = jmp; i_brz = brz; i_zero = zero; i_target = tgt;
    @(negedge clk);
    last_call = o_call; last_rtrn = o_rtrn; last_busy = o_busy; last_pc = o_PC;
    @(posedge clk);
    #1;
    if (last_call && env_sp < 16) begin
      env_mem[env_sp] = last_pc + 8'd1;
      env_sp++;
    end else if (last_rtrn && env_sp > 0) begin
      env_sp--;
      i_stack = env_mem[env_sp];
    end
  endtask

  task automatic idle();              apply_stimulus(1, 0, 0, 0, 0, 0, 8'h00); endtask
  task automatic jump(input logic [7:0] t);  apply_stimulus(1, 0, 0, 1, 0, 0, t); endtask
  task automatic call(input logic [7:0] t);  apply_stimulus(1, 0, 1, 0, 0, 0, t); endtask
  task automatic ret();
    apply_stimulus(1, 1, 0, 0, 0, 0, 8'h00);
    apply_stimulus(1, 0, 1, 1, 0, 0, 8'hEE);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; i_en = 0; i_jmp = 0; i_brz = 0; i_zero = 0; i_call = 0; i_rtrn = 0;
    i_target = 8'h00; i_stack = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    check_output("reset_pc",   o_PC, 8'h00);
    check_output("reset_busy", {7'd0, o_busy}, 8'h00);
    check_output("reset_ovf",  {7'd0, o_ovf},  8'h00);
    check_output("reset_unf",  {7'd0, o_unf},  8'h00);

    for (int i = 1; i <= 4; i++) begin
      idle();
      check_output("inc_pc", o_PC, 8'(i));
    end
    check_output("inc_nostrobe", {6'd0, last_call, last_rtrn}, 8'h00);

    jump(8'h10);
    check_output("jmp_pc", o_PC, 8'h10);
    call(8'h40);
    check_output("call_strobe", {7'd0, last_call}, 8'h01);
    check_output("call_pc", o_PC, 8'h40);
    repeat (3) idle();
    apply_stimulus(1, 1, 0, 0, 0, 0, 8'h00);
    check_output("rtrn_strobe", {7'd0, last_rtrn}, 8'h01);
    check_output("rtrn_hold", o_PC, 8'h43);
    apply_stimulus(1, 0, 1, 1, 0, 0, 8'hEE);
    check_output("rtrn_busy", {7'd0, last_busy}, 8'h01);
    check_output("rtrn_pc", o_PC, 8'h11);

    jump(8'h05);
    call(8'h42);
    call(8'h70);
    ret();
    check_output("nest_ret1", o_PC, 8'h43);
    ret();
    check_output("nest_ret2", o_PC, 8'h06);

    for (int i = 0; i < 16; i++) call(8'h20 + 8'(i));
    check_output("full_pc", o_PC, 8'h2F);
    check_output("full_noovf", {7'd0, o_ovf}, 8'h00);
    call(8'h99);
    check_output("ovf_nostrobe", {7'd0, last_call}, 8'h00);
    check_output("ovf_flag", {7'd0, o_ovf}, 8'h01);
    check_output("ovf_pc", o_PC, 8'h30);
    for (int i = 0; i < 16; i++) begin
      ret();
      if (i == 0) check_output("drain_first", o_PC, 8'h2F);
    end
    check_output("drain_last", o_PC, 8'h07);
    apply_stimulus(1, 1, 0, 0, 0, 0, 8'h00);
    check_output("unf_nostrobe", {7'd0, last_rtrn}, 8'h00);
    check_output("unf_flag", {7'd0, o_unf}, 8'h01);
    check_output("unf_pc", o_PC, 8'h08);

    jump(8'h10);
    apply_stimulus(1, 0, 0, 0, 1, 1, 8'h80);
    check_output("brz_taken", o_PC, 8'h80);
    apply_stimulus(1, 0, 0, 0, 1, 0, 8'h90);
    check_output("brz_not", o_PC, 8'h81);
    apply_stimulus(1, 0, 1, 1, 0, 0, 8'h50);
    check_output("callwins_strobe", {7'd0, last_call}, 8'h01);
    check_output("callwins_pc", o_PC, 8'h50);
    apply_stimulus(1, 1, 1, 0, 0, 0, 8'h99);
    check_output("rtrnwins_strobes", {6'd0, last_call, last_rtrn}, 8'h01);
    apply_stimulus(1, 0, 0, 0, 0, 0, 8'h00);
    check_output("rtrnwins_pc", o_PC, 8'h82);
    jump(8'hFF);
    idle();
    check_output("wrap_pc", o_PC, 8'h00);

    call(8'h60);
    apply_stimulus(1, 1, 0, 0, 0, 0, 8'h00);
    check_output("pre_rst_busy", {7'd0, o_busy}, 8'h01);
    i_en = 0; i_rtrn = 0; i_call = 0; i_jmp = 0; i_brz = 0;
    rst = 1'b1;
    #1;
    check_output("rst_wait_pc", o_PC, 8'h00);
    check_output("rst_wait_busy", {7'd0, o_busy}, 8'h00);
    env_sp = 0;
    i_stack = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst_flags", {6'd0, o_ovf, o_unf}, 8'h00);
    apply_stimulus(0, 0, 1, 0, 0, 0, 8'h33);
    check_output("hold_strobes", {6'd0, last_call, last_rtrn}, 8'h00);
    check_output("hold_pc", o_PC, 8'h00);
    apply_stimulus(1, 1, 0, 0, 0, 0, 8'h00);
    check_output("rst_depth_unf", {7'd0, o_unf}, 8'h01);
    check_output("rst_depth_pc", o_PC, 8'h01);

    idle();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
